// File: rtl/pw_sw_chain.sv
// Power-switch chain sequencer for one gated domain.
// Ramps the header/footer switch segments on in order (bit 0 first) and off in
// reverse order, holding each segment for step_delay+1 cycles to limit rush
// current. sw_ack reports the settled direction and only moves once the chain
// is fully on or fully off, so it stays at its old value for the whole ramp.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// OFF       | all segments off, sw_ack = 0
// RAMP_UP   | adding one segment per (dly_q+1) cycles toward all-on
// ON        | all segments on, sw_ack = 1
// RAMP_DOWN | removing one segment per (dly_q+1) cycles toward all-off
module pw_sw_chain #(
  parameter int N_SEG    = 4,
  parameter int STEP_W   = 8,
  parameter bit RESET_ON = 1'b1
) (
  input  logic              ck,
  input  logic              rst,
  input  logic              en_pw_sw,
  input  logic [STEP_W-1:0] step_delay,
  output logic [N_SEG-1:0]  sw_seg,
  output logic              sw_ack,
  output logic              busy
);

  localparam int CNT_W = $clog2(N_SEG + 1);
  localparam logic [CNT_W-1:0] SEG_FULL = CNT_W'(N_SEG);
  localparam logic [CNT_W-1:0] SEG_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    OFF       = 2'd0,
    RAMP_UP   = 2'd1,
    ON        = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  localparam state_t           RST_STATE = RESET_ON ? ON : OFF;
  localparam logic [CNT_W-1:0] RST_CNT   = RESET_ON ? SEG_FULL : '0;
  localparam logic [N_SEG-1:0] RST_SEG   = {N_SEG{RESET_ON}};

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    seg_cnt, seg_cnt_d;
  logic [STEP_W-1:0]   timer, timer_d;
  logic [STEP_W-1:0]   dly_q, dly_d;
  logic                ack_d;
  logic [N_SEG-1:0]    sw_seg_d;

  // State and datapath registers; reset wins over every other input.
  always_ff @(posedge ck) begin
    if (rst) begin
      state_q <= RST_STATE;
      seg_cnt <= RST_CNT;
      timer   <= '0;
      dly_q   <= '0;
      sw_ack  <= RESET_ON;
      sw_seg  <= RST_SEG;
    end else begin
      state_q <= state_d;
      seg_cnt <= seg_cnt_d;
      timer   <= timer_d;
      dly_q   <= dly_d;
      sw_ack  <= ack_d;
      sw_seg  <= sw_seg_d;
    end
  end

  // Next-state logic: ramp stepping, reversals, and ack updates on settle.
  always_comb begin
    state_d   = state_q;
    seg_cnt_d = seg_cnt;
    timer_d   = timer;
    dly_d     = dly_q;
    ack_d     = sw_ack;
    case (state_q)
      OFF: begin
        if (en_pw_sw) begin
          state_d   = RAMP_UP;
          seg_cnt_d = SEG_ONE;
          timer_d   = '0;
          dly_d     = step_delay;
        end
      end
      RAMP_UP: begin
        if (!en_pw_sw) begin
          // Reversal: step back immediately, sw_ack keeps its value.
          state_d   = RAMP_DOWN;
          seg_cnt_d = seg_cnt - SEG_ONE;
          timer_d   = '0;
          dly_d     = step_delay;
        end else if (timer == dly_q) begin
          if (seg_cnt == SEG_FULL) begin
            state_d = ON;
            ack_d   = 1'b1;
          end else begin
            seg_cnt_d = seg_cnt + SEG_ONE;
            timer_d   = '0;
          end
        end else begin
          timer_d = timer + STEP_W'(1);
        end
      end
      ON: begin
        if (!en_pw_sw) begin
          state_d   = RAMP_DOWN;
          seg_cnt_d = SEG_FULL - SEG_ONE;
          timer_d   = '0;
          dly_d     = step_delay;
        end
      end
      RAMP_DOWN: begin
        if (en_pw_sw) begin
          state_d   = RAMP_UP;
          seg_cnt_d = seg_cnt + SEG_ONE;
          timer_d   = '0;
          dly_d     = step_delay;
        end else if (timer == dly_q) begin
          if (seg_cnt == '0) begin
            state_d = OFF;
            ack_d   = 1'b0;
          end else begin
            seg_cnt_d = seg_cnt - SEG_ONE;
            timer_d   = '0;
          end
        end else begin
          timer_d = timer + STEP_W'(1);
        end
      end
      default: begin
        state_d = RST_STATE;
      end
    endcase
  end

  // Outputs: thermometer decode of the next count (registered into sw_seg)
  // and the ramp indicator.
  always_comb begin
    sw_seg_d = '0;
    for (int i = 0; i < N_SEG; i++) begin
      sw_seg_d[i] = (CNT_W'(i) < seg_cnt_d);
    end
    busy = (state_q == RAMP_UP) || (state_q == RAMP_DOWN);
  end

endmodule

// File: tb/tb_pw_sw_chain.sv
// Self-checking bench for pw_sw_chain: scoreboard against a level/dwell
// reference model, plus directed ramp-timing checks from closed-form formulas.
module tb_pw_sw_chain;
  localparam int N = 4;

  logic         ck = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic [7:0]   sd = 8'd0;
  logic [N-1:0] sw_seg;
  logic         sw_ack;
  logic         busy;

  pw_sw_chain dut (
    .ck(ck), .rst(rst), .en_pw_sw(en), .step_delay(sd),
    .sw_seg(sw_seg), .sw_ack(sw_ack), .busy(busy)
  );

  always #5 ck = ~ck;

  typedef struct packed {
    logic [N-1:0] seg;
    logic         ack;
    logic         bsy;
  } obs_t;

  obs_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  // Reference model: level = segments on, settled/ack/direction, dwell count.
  int   m_lvl = N;
  bit   m_busy = 0;
  bit   m_ack = 1;
  bit   m_up = 1;
  int   m_wait = 0;
  int   m_d = 0;

  function automatic logic [N-1:0] therm(input int k);
    therm = N'((32'd1 << k) - 32'd1);
  endfunction

  task automatic model_step(input logic r, input logic e, input int d);
    if (r) begin
      m_lvl = N; m_busy = 0; m_ack = 1; m_wait = 0; m_d = 0;
    end else if (!m_busy) begin
      if (e != m_ack) begin
        m_busy = 1; m_up = e; m_d = d; m_wait = 0;
        m_lvl += e ? 1 : -1;
      end
    end else if (e != m_up) begin
      m_up = e; m_d = d; m_wait = 0;
      m_lvl += e ? 1 : -1;
    end else if (m_wait == m_d) begin
      if (m_lvl == (m_up ? N : 0)) begin
        m_busy = 0; m_ack = m_up;
      end else begin
        m_lvl += m_up ? 1 : -1;
        m_wait = 0;
      end
    end else begin
      m_wait++;
    end
  endtask

  // Drive one cycle of stimulus and queue the response the next edge must give.
  task automatic cyc(input logic r, input logic e, input int d);
    obs_t x;
    @(negedge ck);
    rst = r; en = e; sd = 8'(d);
    model_step(r, e, d);
    x.seg = therm(m_lvl); x.ack = m_ack; x.bsy = m_busy;
    exp_q.push_back(x);
  endtask

  task automatic check(input string nm, input obs_t act, input obs_t req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s t=%0t got seg=%b ack=%b busy=%b want seg=%b ack=%b busy=%b",
               nm, $time, act.seg, act.ack, act.bsy, req.seg, req.ack, req.bsy);
    end
  endtask

  // Monitor: compare every presented output against the scoreboard head.
  initial begin
    forever begin
      obs_t x;
      @(posedge ck);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check("scoreboard", {sw_seg, sw_ack, busy}, x);
      end
    end
  end

  // Closed-form ramp timing from a settled state; step_delay is disturbed
  // after the start edge and must be ignored.
  task automatic ramp_check(input logic e, input int d, input string nm);
    int t_end;
    int ones;
    logic [N-1:0] es;
    t_end = N * (d + 1) + 1;
    cyc(0, e, d);
    for (int m = 1; m <= t_end; m++) begin
      @(posedge ck);
      #2;
      ones = 0;
      for (int i = 0; i < N; i++) if (i * (d + 1) + 1 <= m) ones++;
      es = e ? therm(ones) : therm(N - ones);
      check(nm, {sw_seg, sw_ack, busy},
            {es, (e ? (m >= t_end) : (m < t_end)), (m < t_end)});
      cyc(0, e, (d + 7) & 255);
    end
  endtask

  // Reversal at edge 6 of a d=3 ramp started from a settled state.
  task automatic rev_check(input logic e, input string nm);
    for (int k = 0; k <= 20; k++) begin
      cyc(0, (k < 6) ? e : !e, 3);
      @(posedge ck);
      #2;
      if (k + 1 == 7)
        check({nm, "_at7"}, {sw_seg, sw_ack, 1'b0}, {(e ? 4'b0001 : 4'b0111), !e, 1'b0});
      else if (k + 1 == 11)
        check({nm, "_at11"}, {sw_seg, sw_ack, 1'b0}, {(e ? 4'b0000 : 4'b1111), !e, 1'b0});
      else
        check({nm, "_ack"}, {{N{1'b0}}, sw_ack, 1'b0}, {{N{1'b0}}, !e, 1'b0});
    end
  endtask

  task automatic settle(input logic e);
    for (int k = 0; k < 3000; k++) begin
      if (!m_busy && m_ack == e) break;
      cyc(0, e, 0);
    end
  endtask

  initial begin
    int hold;
    logic e;
    // Reset into the fully-on state.
    cyc(1, 1, 0);
    @(posedge ck); #2;
    check("reset", {sw_seg, sw_ack, busy}, {4'b1111, 1'b1, 1'b0});
    cyc(0, 1, 0);
    ramp_check(0, 3, "off_ramp_d3");
    ramp_check(1, 3, "on_ramp_d3");
    settle(0);
    ramp_check(1, 0, "on_ramp_d0");
    ramp_check(0, 0, "off_ramp_d0");
    settle(0);
    rev_check(1, "rev_up_to_down");
    settle(1);
    rev_check(0, "rev_down_to_up");
    settle(1);
    // Reset in the middle of an off-ramp.
    for (int k = 0; k < 6; k++) cyc(0, 0, 3);
    cyc(1, 0, 3);
    @(posedge ck); #2;
    check("rst_mid_ramp", {sw_seg, sw_ack, busy}, {4'b1111, 1'b1, 1'b0});
    // Single-cycle request pulse from OFF still starts a ramp.
    settle(0);
    cyc(0, 1, 2);
    @(posedge ck); #2;
    check("pulse_start", {sw_seg, sw_ack, busy}, {4'b0001, 1'b0, 1'b1});
    settle(0);
    // Randomized traffic against the model.
    e = 1'b1;
    hold = 0;
    for (int k = 0; k < 1500; k++) begin
      if (hold == 0) begin
        e = ~e;
        hold = $urandom_range(1, 40);
      end
      hold--;
      cyc(($urandom_range(0, 199) == 0), e, $urandom_range(0, 5));
    end
    @(posedge ck); #3;
    @(posedge ck); #3;
    if (exp_q.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout t=%0t limit reached", $time);
    $fatal(1, "timeout");
  end

endmodule
